// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter granting two requesters access to one
// shared external 5-bit ripple adder. Each operation walks
// IDLE -> CAP -> WAIT (HOLD_CYCLES cycles) -> DONE.
// Optional feature macro: ADDER_ARBITER_SUBTRACT_EN enables X-Y via op = 1.
module adder_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [4:0] x0,
  input  logic [4:0] y0,
  input  logic [4:0] x1,
  input  logic [4:0] y1,
  input  logic       op0,
  input  logic       op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done,
  output logic       owner,
  output logic [4:0] sum,
  output logic       cout,
  output logic [4:0] add_x,
  output logic [4:0] add_y,
  output logic       add_cin,
  input  logic [4:0] add_s,
  input  logic       add_cout
);

  localparam int unsigned W  = 5;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAP  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_last;
  logic           r_owner;
  logic           r_gnt0;
  logic           r_gnt1;
  logic           r_done;
  logic [W-1:0]   r_sum;
  logic           r_cout;
  logic [W-1:0]   r_ax;
  logic [W-1:0]   r_ay;
  logic           r_cin;
  logic [CW-1:0]  r_cnt;

  logic           w_win;
  logic [W-1:0]   w_x;
  logic [W-1:0]   w_y;
  logic [W-1:0]   w_y_eff;
  logic           w_cin_eff;

  // Round-robin winner: on a tie the requester not served last wins
  always_comb begin
    w_win = req1;
    if (req0 && req1) begin
      w_win = ~r_last;
    end
  end

  // Select the current owner's operands for latching at CAP exit
  always_comb begin
    w_x = r_owner ? x1 : x0;
    w_y = r_owner ? y1 : y0;
  end

`ifdef ADDER_ARBITER_SUBTRACT_EN
  logic w_op;

  // Subtract as X + ~Y + 1 when the owner's op is 1
  always_comb begin
    w_op      = r_owner ? op1 : op0;
    w_y_eff   = w_op ? ~w_y : w_y;
    w_cin_eff = w_op;
  end
`else
  logic w_unused_op;

  // Add-only build: op inputs have no effect
  always_comb begin
    w_unused_op = op0 ^ op1;
    w_y_eff     = w_y;
    w_cin_eff   = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req0 || req1) w_next = S_CAP;
      S_CAP:  w_next = S_WAIT;
      S_WAIT: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered grants, operands, counter and results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ax    <= '0;
      r_ay    <= '0;
      r_cin   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_owner <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
          end
        end
        S_CAP: begin
          r_ax  <= w_x;
          r_ay  <= w_y_eff;
          r_cin <= w_cin_eff;
          r_cnt <= HOLD_M1;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_sum  <= add_s;
            r_cout <= add_cout;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          r_last <= r_owner;
        end
        default: begin
          r_done <= 1'b0;
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping
  always_comb begin
    gnt0    = r_gnt0;
    gnt1    = r_gnt1;
    done    = r_done;
    owner   = r_owner;
    sum     = r_sum;
    cout    = r_cout;
    add_x   = r_ax;
    add_y   = r_ay;
    add_cin = r_cin;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (HOLD_CYCLES = 1 and 4).
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, r4_req0;
  logic [4:0] x0, y0, x1, y1;
  logic       op0, op1;

  logic       gnt0, gnt1, done, owner, cout, add_cin, add_cout;
  logic [4:0] sum, add_x, add_y, add_s;
  logic       g0_4, g1_4, done_4, owner_4, cout_4, cin_4, acout_4;
  logic [4:0] sum_4, ax_4, ay_4, as_4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .owner(owner),
    .sum(sum), .cout(cout), .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  adder_arbiter #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .req0(r4_req0), .req1(1'b0),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .op0(op0), .op1(op1),
    .gnt0(g0_4), .gnt1(g1_4), .done(done_4), .owner(owner_4),
    .sum(sum_4), .cout(cout_4), .add_x(ax_4), .add_y(ay_4), .add_cin(cin_4),
    .add_s(as_4), .add_cout(acout_4)
  );

  // Behavioural shared ripple adders
  always_comb {add_cout, add_s} = 6'(add_x) + 6'(add_y) + 6'(add_cin);
  always_comb {acout_4, as_4}   = 6'(ax_4) + 6'(ay_4) + 6'(cin_4);

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 0; req1 = 0; r4_req0 = 0;
    x0 = 0; y0 = 0; x1 = 0; y1 = 0; op0 = 0; op1 = 0;
    tick(); tick();
    n_cmp++;
    if ({gnt0, gnt1, done, owner, cout, sum} !== 10'd0) begin
      n_err++; $display("FAIL reset_outs got %b want 0", {gnt0, gnt1, done, owner, cout, sum});
    end
    n_cmp++;
    if ({add_x, add_y, add_cin} !== 11'd0) begin
      n_err++; $display("FAIL reset_adder got %b want 0", {add_x, add_y, add_cin});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_req0;
    req0 = 1; x0 = 5'd7; y0 = 5'd8;
    tick(); // CAP
    n_cmp++;
    if ({gnt0, gnt1, owner, done} !== 4'b1000) begin
      n_err++; $display("FAIL c1_cap got %b want 1000", {gnt0, gnt1, owner, done});
    end
    req0 = 0;
    tick(); // WAIT
    n_cmp++;
    if ({gnt0, done} !== 2'b10) begin
      n_err++; $display("FAIL c1_wait got %b want 10", {gnt0, done});
    end
    tick(); // DONE, cycle 3
    n_cmp++;
    if ({gnt0, gnt1, done, owner, cout, sum} !== {4'b1010, 1'b0, 5'b01111}) begin
      n_err++; $display("FAIL c1_done got %b want 1010001111", {gnt0, gnt1, done, owner, cout, sum});
    end
    tick(); // IDLE
    n_cmp++;
    if ({gnt0, gnt1, done, sum} !== {3'b000, 5'b01111}) begin
      n_err++; $display("FAIL c1_idle got %b want 00001111", {gnt0, gnt1, done, sum});
    end
  endtask

  task automatic test_add_req1;
    logic [4:0] xs [2];
    logic [4:0] ys [2];
    logic [5:0] exp [2];
    xs[0] = 5'd31; ys[0] = 5'd1;  exp[0] = 6'b1_00000;
    xs[1] = 5'd15; ys[1] = 5'd15; exp[1] = 6'b0_11110;
    for (int i = 0; i < 2; i++) begin
      req1 = 1; x1 = xs[i]; y1 = ys[i];
      tick(); // CAP
      n_cmp++;
      if ({gnt0, gnt1, owner} !== 3'b011) begin
        n_err++; $display("FAIL c2_cap%0d got %b want 011", i, {gnt0, gnt1, owner});
      end
      req1 = 0;
      tick(); tick(); // DONE
      n_cmp++;
      if ({done, owner, cout, sum} !== {2'b11, exp[i]}) begin
        n_err++; $display("FAIL c2_done%0d got %b want %b", i, {done, owner, cout, sum}, {2'b11, exp[i]});
      end
      tick();
    end
  endtask

  task automatic test_round_robin;
    logic exp_own;
    rst = 1; tick(); rst = 0;
    req0 = 1; req1 = 1; x0 = 5'd1; y0 = 5'd2; x1 = 5'd4; y1 = 5'd8;
    exp_own = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); // CAP
      n_cmp++;
      if ({gnt0, gnt1, owner} !== {~exp_own, exp_own, exp_own}) begin
        n_err++; $display("FAIL c3_cap%0d got %b want %b", i, {gnt0, gnt1, owner}, {~exp_own, exp_own, exp_own});
      end
      tick(); // WAIT
      n_cmp++;
      if (gnt0 && gnt1) begin
        n_err++; $display("FAIL c3_overlap%0d got 11 want not both", i);
      end
      tick(); // DONE
      n_cmp++;
      if ({done, sum} !== {1'b1, (exp_own ? 5'd12 : 5'd3)}) begin
        n_err++; $display("FAIL c3_done%0d got %b want %b", i, {done, sum}, {1'b1, (exp_own ? 5'd12 : 5'd3)});
      end
      tick(); // IDLE despite requests still high
      n_cmp++;
      if ({gnt0, gnt1, done} !== 3'b000) begin
        n_err++; $display("FAIL c3_idle%0d got %b want 000", i, {gnt0, gnt1, done});
      end
      exp_own = ~exp_own;
    end
    req0 = 0; req1 = 0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_subtract;
    logic [4:0] xs [2];
    logic [4:0] ys [2];
    logic [5:0] exp [2];
    xs[0] = 5'd9; ys[0] = 5'd3;
    xs[1] = 5'd3; ys[1] = 5'd9;
`ifdef ADDER_ARBITER_SUBTRACT_EN
    exp[0] = 6'b1_00110; exp[1] = 6'b0_11010;
`else
    exp[0] = 6'b0_01100; exp[1] = 6'b0_01100;
`endif
    for (int i = 0; i < 2; i++) begin
      req0 = 1; op0 = 1; x0 = xs[i]; y0 = ys[i];
      tick(); req0 = 0;
      tick(); tick(); // DONE
      n_cmp++;
      if ({done, cout, sum} !== {1'b1, exp[i]}) begin
        n_err++; $display("FAIL c4_sub%0d got %b want %b", i, {done, cout, sum}, {1'b1, exp[i]});
      end
      tick();
    end
    op0 = 0;
  endtask

  task automatic test_reset_mid_op;
    req0 = 1; x0 = 5'd20; y0 = 5'd2;
    tick(); tick(); // WAIT
    rst = 1; #1;
    n_cmp++;
    if ({gnt0, gnt1, done, owner, cout, sum, add_x} !== 15'd0) begin
      n_err++; $display("FAIL c5_rst got %b want 0", {gnt0, gnt1, done, owner, cout, sum, add_x});
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL c5_nodone got %b want 0", done);
    end
    rst = 0; x0 = 5'd5; y0 = 5'd6;
    tick(); tick(); tick(); // CAP, WAIT, DONE
    n_cmp++;
    if ({done, gnt0, owner, cout, sum} !== {4'b1100, 5'd11}) begin
      n_err++; $display("FAIL c5_fresh got %b want %b", {done, gnt0, owner, cout, sum}, {4'b1100, 5'd11});
    end
    req0 = 0;
    tick(); tick();
  endtask

  task automatic test_hold4_drop;
    r4_req0 = 1; x0 = 5'd10; y0 = 5'd4;
    tick(); // cycle 1 CAP
    n_cmp++;
    if ({g0_4, done_4} !== 2'b10) begin
      n_err++; $display("FAIL c6_cap got %b want 10", {g0_4, done_4});
    end
    tick(); // cycle 2 WAIT
    r4_req0 = 0; x0 = 5'd0; y0 = 5'd0;
    for (int c = 3; c <= 5; c++) begin
      tick();
      n_cmp++;
      if ({done_4, g0_4, ax_4, ay_4} !== {2'b01, 5'd10, 5'd4}) begin
        n_err++; $display("FAIL c6_wait%0d got %b want %b", c, {done_4, g0_4, ax_4, ay_4}, {2'b01, 5'd10, 5'd4});
      end
    end
    tick(); // cycle 6 DONE
    n_cmp++;
    if ({done_4, g0_4, cout_4, sum_4} !== {3'b110, 5'd14}) begin
      n_err++; $display("FAIL c6_done got %b want %b", {done_4, g0_4, cout_4, sum_4}, {3'b110, 5'd14});
    end
    tick();
    n_cmp++;
    if ({done_4, g0_4} !== 2'b00) begin
      n_err++; $display("FAIL c6_idle got %b want 00", {done_4, g0_4});
    end
  endtask

  initial begin
    test_reset();
    test_add_req0();
    test_add_req1();
    test_round_robin();
    test_subtract();
    test_reset_mid_op();
    test_hold4_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
